// File: rtl/key_event_fifo_pkg.sv
// key_event_fifo_pkg
//   Shared definitions for the keypad event conditioner: FSM state
//   encoding, key code width, default parameter values and a small
//   elaboration helper.
package key_event_fifo_pkg;

  localparam int KEY_CODE_W = 4;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_DEPTH           = 4;
  localparam int DEF_REPEAT_DELAY    = 1024;
  localparam int DEF_REPEAT_PERIOD   = 256;

  typedef logic [KEY_CODE_W-1:0] key_code_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_e;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/key_event_fifo_queue.sv
// key_event_queue
//   First-word-fall-through circular buffer for debounced key events.
//   Pointers carry one extra wrap bit so full and empty are distinct.
//
// Ports
//   clk         system clock
//   nst         asynchronous active-low reset
//   push        enqueue push_code this cycle
//   push_code   code to enqueue
//   pop_ready   consumer accepts the head when the queue is non-empty
//   head_code   code at the head (0 when empty)
//   head_valid  queue non-empty
//   overflow    registered pulse: a push was dropped because the queue was full
//   level       number of queued entries
module key_event_queue
  import key_event_fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   nst,
  input  logic                   push,
  input  key_code_t              push_code,
  input  logic                   pop_ready,
  output key_code_t              head_code,
  output logic                   head_valid,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  key_code_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop in the same cycle frees the slot, so a push into a full queue
  // is still accepted when the consumer is draining the head.
  assign do_pop  = !empty && pop_ready;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge nst) begin
    if (!nst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      overflow <= push && !do_push;
    end
  end

  // Storage needs no reset: head_code is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_code;
  end

  assign head_valid = !empty;
  assign head_code  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign level      = wr_ptr - rd_ptr;

endmodule

// File: rtl/key_event_fifo.sv
// key_event_fifo
//   Turns raw 4x4 keypad-scanner output into debounced single-shot key
//   events and buffers them in a small FWFT queue with valid/ready.
//
//   Optional feature macro: KEY_REPEAT_EN
//     defined   - holding a key re-issues its code after REPEAT_DELAY held
//                 cycles, then every REPEAT_PERIOD cycles
//     undefined - exactly one event per press, no repeat logic
//
// Ports
//   clk        system clock
//   nst        asynchronous active-low reset
//   key_down   scanner reports a key pressed this cycle
//   key_code   scanned key number (valid with key_down)
//   out_code   code at the head of the queue
//   out_valid  queue non-empty
//   out_ready  consumer accepts the head
//   overflow   one-cycle pulse: an event was dropped, queue full
//   level      entries currently queued
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no key; first key_down sample latches the code
// DEBOUNCE | counting stable samples of the latched code
// HELD     | event issued; key still down, other codes ignored
// RELEASE  | key seen up; counting low samples, a high sample is a bounce
module key_event_fifo
  import key_event_fifo_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                   clk,
  input  logic                   nst,
  input  logic                   key_down,
  input  logic [KEY_CODE_W-1:0]  key_code,
  output logic [KEY_CODE_W-1:0]  out_code,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] level
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_event_fifo: DEBOUNCE_CYCLES must be at least 2");
  end
  if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("key_event_fifo: DEPTH must be a power of two, at least 2");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("key_event_fifo: need 1 <= REPEAT_PERIOD <= REPEAT_DELAY");
  end

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  key_state_e    state;
  key_state_e    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  key_code_t     cur_code;
  key_code_t     code_nxt;
  logic          push;

`ifdef KEY_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] RPT_DELAY_LD  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LD = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] RPT_ONE       = RW'(1);

  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_nxt;
`endif

  always_ff @(posedge clk or negedge nst) begin
    if (!nst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      cur_code <= '0;
`ifdef KEY_REPEAT_EN
      rpt_cnt  <= '0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_code <= code_nxt;
`ifdef KEY_REPEAT_EN
      rpt_cnt  <= rpt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    code_nxt  = cur_code;
    push      = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_nxt   = rpt_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (key_down) begin
          code_nxt  = key_code;
          cnt_nxt   = '0;
          state_nxt = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (!key_down || key_code != cur_code) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          push      = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_HELD;
`ifdef KEY_REPEAT_EN
          // Down-counter: reaches zero after REPEAT_DELAY held cycles.
          rpt_nxt   = RPT_DELAY_LD;
`endif
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!key_down) begin
          cnt_nxt   = '0;
          state_nxt = ST_RELEASE;
        end else begin
`ifdef KEY_REPEAT_EN
          if (rpt_cnt == '0) begin
            push    = 1'b1;
            rpt_nxt = RPT_PERIOD_LD;
          end else begin
            rpt_nxt = rpt_cnt - RPT_ONE;
          end
`endif
        end
      end
      ST_RELEASE: begin
        // The repeat counter is frozen here so a bounce that returns to
        // HELD resumes the same repeat schedule; it clears only once the
        // release is confirmed.
        if (key_down) begin
          cnt_nxt   = '0;
          state_nxt = ST_HELD;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = ST_IDLE;
`ifdef KEY_REPEAT_EN
          rpt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  key_event_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .nst        (nst),
    .push       (push),
    .push_code  (cur_code),
    .pop_ready  (out_ready),
    .head_code  (out_code),
    .head_valid (out_valid),
    .overflow   (overflow),
    .level      (level)
  );

endmodule

// File: tb/tb_key_event_fifo.sv
module tb_key_event_fifo;

  localparam int DC    = 4;
  localparam int DEPTH = 4;
  localparam int RD    = 32;
  localparam int RP    = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nst = 1'b0;
  logic          key_down = 1'b0;
  logic [3:0]    key_code = 4'd0;
  logic          out_ready = 1'b0;
  logic [3:0]    out_code;
  logic          out_valid;
  logic          overflow;
  logic [LW-1:0] level;

  key_event_fifo #(
    .DEBOUNCE_CYCLES (DC),
    .DEPTH           (DEPTH),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .nst       (nst),
    .key_down  (key_down),
    .key_code  (key_code),
    .out_code  (out_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int ovf_seen = 0;
  int hs_cnt = 0;
  bit rnd_ready = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on run lengths of the sampled input: a press is accepted once the
  // same code has been seen DEBOUNCE_CYCLES+1 samples in a row, and the key
  // is re-armed after DEBOUNCE_CYCLES+1 consecutive low samples.
  int         run;
  logic [3:0] run_code;
  bit         armed;
  int         low_run;
  int         held_age;
  logic [3:0] mfifo[$];
  logic [3:0] exp_q[$];
  bit         exp_ovf;

  always @(posedge clk or negedge nst) begin : model
    bit         ev;
    bit         pop;
    if (!nst) begin
      run = 0; run_code = 0; armed = 1; low_run = 0; held_age = 0;
      mfifo.delete(); exp_q.delete(); exp_ovf = 0;
    end else begin
      ev = 0;
      if (armed) begin
        if (key_down && run > 0 && key_code == run_code) run++;
        else if (key_down && run == 0) begin run = 1; run_code = key_code; end
        else run = 0;
        if (run == DC + 1) begin
          ev = 1; armed = 0; low_run = 0; held_age = 0; run = 0;
        end
      end else begin
        if (!key_down) begin
          low_run++;
          if (low_run == DC + 1) armed = 1;
        end else begin
          low_run = 0;
`ifdef KEY_REPEAT_EN
          held_age++;
          if (held_age >= RD && (held_age - RD) % RP == 0) ev = 1;
`endif
        end
      end
      pop = (mfifo.size() > 0) && out_ready;
      exp_ovf = 0;
      if (ev && mfifo.size() == DEPTH && !pop) begin
        exp_ovf = 1;
      end else begin
        if (pop) void'(mfifo.pop_front());
        if (ev) begin
          mfifo.push_back(run_code);
          exp_q.push_back(run_code);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always begin
    @(negedge clk);
    #1;
    if (nst) begin
      chk("out_valid", out_valid, mfifo.size() != 0);
      chk("level", level, mfifo.size());
      chk("overflow", overflow, exp_ovf);
      if (mfifo.size() > 0) chk("head_code", out_code, mfifo[0]);
      if (overflow) ovf_seen++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("popped_code", out_code, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input bit kd, input logic [3:0] c, input int n);
    key_down = kd;
    key_code = c;
    repeat (n) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    hold(0, 0, DEPTH + 3);
    out_ready = 1'b0;
    hold(0, 0, 1);
    chk("drained_level", level, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_code"}, out_code, 0);
    chk({tag, "_level"}, level, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] codes[5];
    logic [3:0] c;
    int kind;

    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    nst = 1'b1;
    hold(0, 0, 2);

    // single long press, consumer stalled
    hold(1, 5, 20);
    hold(0, 0, DC + 4);
    chk("t1_level", level, 1);
    chk("t1_code", out_code, 5);
    drain();

    // too-short press
    hold(1, 7, 2);
    hold(0, 0, DC + 4);
    chk("t2_valid", out_valid, 0);

    // release glitch absorbed
    hold(1, 3, DC + 3);
    hold(0, 0, 2);
    hold(1, 3, 10);
    hold(0, 0, DC + 4);
    chk("t3_level", level, 1);
    chk("t3_code", out_code, 3);
    drain();

    // overflow on fifth press
    codes = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd8};
    ovf_seen = 0;
    for (int i = 0; i < 5; i++) begin
      hold(1, codes[i], DC + 2);
      hold(0, 0, DC + 4);
    end
    chk("t4_level", level, 4);
    chk("t4_head", out_code, 1);
    chk("t4_ovf_pulses", ovf_seen, 1);
    drain();

    // full queue, fifth push coincident with a pop
    codes = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
    for (int i = 0; i < 4; i++) begin
      hold(1, codes[i], DC + 2);
      hold(0, 0, DC + 4);
    end
    ovf_seen = 0;
    hold(1, codes[4], DC);
    out_ready = 1'b1;
    hold(1, codes[4], 1);
    out_ready = 1'b0;
    hold(1, codes[4], 3);
    hold(0, 0, DC + 4);
    chk("t5_ovf_pulses", ovf_seen, 0);
    chk("t5_level", level, 4);
    chk("t5_head", out_code, 11);

    // reset mid-debounce with queued events
    hold(1, 2, 2);
    nst = 1'b0;
    #1 check_zero("t6");
    @(negedge clk);
    key_down = 1'b0;
    @(negedge clk);
    nst = 1'b1;
    hold(0, 0, 3);

    // randomized presses, glitches and consumer stalls
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      kind = $urandom_range(0, 3);
      case (kind)
        0: hold(1, c, $urandom_range(1, DC));
        1: hold(1, c, $urandom_range(DC + 1, DC + 12));
        2: begin
          hold(1, c, $urandom_range(DC + 1, DC + 6));
          hold(0, 0, $urandom_range(1, 2));
          hold(1, 4'($urandom_range(0, 15)), $urandom_range(1, 8));
        end
        default: begin
          hold(1, c, $urandom_range(1, DC));
          hold(1, c ^ 4'($urandom_range(1, 15)), $urandom_range(DC + 1, DC + 6));
        end
      endcase
      hold(0, 0, $urandom_range(DC + 3, DC + 8));
    end
    rnd_ready = 0;
    drain();
    chk("random_scoreboard_empty", exp_q.size(), 0);

`ifdef KEY_REPEAT_EN
    // auto-repeat: events at accept, +32, +40, +48, +56
    hs_cnt = 0;
    out_ready = 1'b1;
    hold(1, 9, 60);
    out_ready = 1'b0;
    hold(1, 9, 3);
    chk("t8_repeat_pops", hs_cnt, 4);
    chk("t8_level", level, 1);
    chk("t8_code", out_code, 9);
    nst = 1'b0;
    #1 check_zero("t8_reset");
    @(negedge clk);
    key_down = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
